// File: rtl/audio_pdm_out.sv
// Audio output stage: per-line duty of the sound bit -> amplitude, mute/fade gain, sigma-delta PDM pin.
// Define AUDIO_IIR_EN to smooth the line amplitude with a first-order IIR (shift IIR_SHIFT).
module audio_pdm_out #(
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned FADE_DIV  = 4,
  parameter int unsigned IIR_SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sound,
  input  logic [9:0] x,
  input  logic       enable,
  output logic       audio_out,
  output logic [3:0] gain,
  output logic [9:0] level
);

  // state     | meaning
  // MUTE      | gain held at 0, waiting for enable
  // RAMP_UP   | gain +1 every FADE_DIV line strobes
  // PLAY      | gain held at 15
  // RAMP_DOWN | gain -1 every FADE_DIV line strobes
  typedef enum logic [1:0] {
    S_MUTE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_PLAY      = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [10:0] H_TOT11  = 11'(H_TOTAL);
  localparam logic [7:0]  DIV_LAST = 8'(FADE_DIV - 1);

  if (FADE_DIV == 0 || FADE_DIV > 255 || IIR_SHIFT == 0 || IIR_SHIFT > 8 ||
      H_TOTAL < 2 || H_TOTAL > 1023) begin : g_bad_param
    $error("audio_pdm_out: parameter out of range");
  end

  state_t      state;
  logic [7:0]  div_cnt;
  logic [9:0]  pix_count;
  logic [9:0]  sample;
  logic        line_strobe;
  logic [13:0] prod;
  logic [9:0]  scaled;
  logic [10:0] acc;
  logic [10:0] sd_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_count   <= '0;
      sample      <= '0;
      line_strobe <= 1'b0;
    end else begin
      line_strobe <= (x == X_LAST);
      if (x == X_LAST) begin
        sample    <= pix_count + {9'd0, sound};
        pix_count <= '0;
      end else begin
        pix_count <= pix_count + {9'd0, sound};
      end
    end
  end

`ifdef AUDIO_IIR_EN
  logic signed [10:0] iir_diff;
  logic signed [10:0] iir_step;

  // Floor shift: rising steps stall short of the target, falling steps land on it.
  always_comb begin
    iir_diff = $signed({1'b0, sample}) - $signed({1'b0, level});
    iir_step = iir_diff >>> IIR_SHIFT;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= '0;
    end else if (line_strobe) begin
`ifdef AUDIO_IIR_EN
      level <= level + iir_step[9:0];
`else
      level <= sample;
`endif
    end
  end

  // A state change resets the divider and takes the place of that strobe's gain step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_MUTE;
      gain    <= 4'd0;
      div_cnt <= 8'd0;
    end else if (line_strobe) begin
      case (state)
        S_MUTE: begin
          if (enable) begin
            state   <= S_RAMP_UP;
            div_cnt <= 8'd0;
          end
        end
        S_RAMP_UP: begin
          if (!enable) begin
            state   <= S_RAMP_DOWN;
            div_cnt <= 8'd0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            if (gain == 4'd15) begin
              state <= S_PLAY;
            end else begin
              gain <= gain + 4'd1;
              if (gain == 4'd14) state <= S_PLAY;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_PLAY: begin
          if (!enable) begin
            state   <= S_RAMP_DOWN;
            div_cnt <= 8'd0;
          end
        end
        S_RAMP_DOWN: begin
          if (enable) begin
            state   <= S_RAMP_UP;
            div_cnt <= 8'd0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            if (gain == 4'd0) begin
              state <= S_MUTE;
            end else begin
              gain <= gain - 4'd1;
              if (gain == 4'd1) state <= S_MUTE;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          state   <= S_MUTE;
          gain    <= 4'd0;
          div_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign prod   = {4'd0, level} * {10'd0, gain};
  assign scaled = 10'(prod >> 4);
  assign sd_sum = acc + {1'b0, scaled};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      audio_out <= 1'b0;
    end else if (sd_sum >= H_TOT11) begin
      acc       <= sd_sum - H_TOT11;
      audio_out <= 1'b1;
    end else begin
      acc       <= sd_sum;
      audio_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_pdm_out.sv
// Directed bench for audio_pdm_out: two instances (FADE_DIV 1 and 2) share one stimulus stream of 800-pixel lines.
module tb_audio_pdm_out;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sound;
  logic [9:0] x;
  logic       enable;
  logic       ao_a, ao_b;
  logic [3:0] gain_a, gain_b;
  logic [9:0] level_a, level_b;

  int n_tests = 0;
  int n_fail  = 0;
  int ones_a, ones_b;
  logic [3:0] snap_gain_a, snap_gain_b, r_gain_a, r_gain_b;
  logic [9:0] snap_lvl_a, snap_lvl_b, r_lvl_a, r_lvl_b;
  logic       r_ao_a, r_ao_b;

  always #5 clk = ~clk;

  audio_pdm_out #(.H_TOTAL(800), .FADE_DIV(1), .IIR_SHIFT(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .sound(sound), .x(x), .enable(enable),
    .audio_out(ao_a), .gain(gain_a), .level(level_a));

  audio_pdm_out #(.H_TOTAL(800), .FADE_DIV(2), .IIR_SHIFT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .sound(sound), .x(x), .enable(enable),
    .audio_out(ao_b), .gain(gain_b), .level(level_b));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_a(input int m);
    if (m == 0) return 0;
    return (m - 1 > 15) ? 15 : m - 1;
  endfunction

  function automatic int exp_b(input int m);
    if (m == 0) return 0;
    return ((m - 1) / 2 > 15) ? 15 : (m - 1) / 2;
  endfunction

  // pat: 0 silent, 1 full line, 2 pixels 256..511. Snapshot at i=5 shows the previous line's strobe.
  task automatic run_line(input int pat, input int rst_at, input bit glitch, input bit no_end);
    logic en_saved;
    en_saved = enable;
    ones_a = 0;
    ones_b = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      ones_a += int'(ao_a);
      ones_b += int'(ao_b);
      if (i == 5) begin
        snap_gain_a = gain_a; snap_gain_b = gain_b;
        snap_lvl_a  = level_a; snap_lvl_b = level_b;
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        r_ao_a = ao_a; r_gain_a = gain_a; r_lvl_a = level_a;
        r_ao_b = ao_b; r_gain_b = gain_b; r_lvl_b = level_b;
        rst_n = 1'b1;
      end
      if (i == rst_at) rst_n = 1'b0;
      x = no_end ? 10'(i % 700) : 10'(i);
      case (pat)
        1:       sound = 1'b1;
        2:       sound = (i >= 256 && i < 512);
        default: sound = 1'b0;
      endcase
      if (glitch) enable = (i >= 300 && i < 310) ? !en_saved : en_saved;
    end
  endtask

  task automatic check_reset_snap(input string tag);
    n_tests++;
    if (r_ao_a !== 1'b0 || r_gain_a !== 4'd0 || r_lvl_a !== 10'd0) begin
      n_fail++;
      $display("FAIL %s dut_a: got ao=%0d gain=%0d level=%0d expected all 0", tag, r_ao_a, r_gain_a, r_lvl_a);
    end
    n_tests++;
    if (r_ao_b !== 1'b0 || r_gain_b !== 4'd0 || r_lvl_b !== 10'd0) begin
      n_fail++;
      $display("FAIL %s dut_b: got ao=%0d gain=%0d level=%0d expected all 0", tag, r_ao_b, r_gain_b, r_lvl_b);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; sound = 1'b0; x = 10'd0;
    repeat (3) @(negedge clk);
    r_ao_a = ao_a; r_gain_a = gain_a; r_lvl_a = level_a;
    r_ao_b = ao_b; r_gain_b = gain_b; r_lvl_b = level_b;
    check_reset_snap("reset_values");
    rst_n = 1'b1;
  endtask

`ifdef AUDIO_IIR_EN
  task automatic test_iir;
    int mdl, prev, s;
    mdl = 0; prev = -1;
    for (int k = 1; k <= 95; k++) begin
      s = (k <= 45) ? 800 : 0;
      run_line((k <= 45) ? 1 : 0, -1, 1'b0, 1'b0);
      if (prev >= 0) mdl = mdl + ((prev - mdl) >>> 3);
      n_tests++;
      if (snap_lvl_a !== 10'(mdl)) begin
        n_fail++;
        $display("FAIL iir_level line %0d: got %0d expected %0d", k, snap_lvl_a, mdl);
      end
      prev = s;
      if (k == 2 || k == 3 || k == 4 || k == 45 || k == 95) begin
        int want;
        want = (k == 2) ? 100 : (k == 3) ? 187 : (k == 4) ? 263 : (k == 45) ? 793 : 0;
        n_tests++;
        if (snap_lvl_a !== 10'(want)) begin
          n_fail++;
          $display("FAIL iir_fixed line %0d: got %0d expected %0d", k, snap_lvl_a, want);
        end
      end
    end
  endtask
`else
  task automatic test_silence;
    for (int n = 1; n <= 10; n++) begin
      run_line(0, -1, 1'b0, 1'b0);
      n_tests++;
      if (ones_a != 0) begin
        n_fail++;
        $display("FAIL silence_ones line %0d: got %0d expected 0", n, ones_a);
      end
      n_tests++;
      if (snap_lvl_a !== 10'd0) begin
        n_fail++;
        $display("FAIL silence_level line %0d: got %0d expected 0", n, snap_lvl_a);
      end
      n_tests++;
      if (snap_gain_a !== 4'(exp_a(n - 1)) || snap_gain_b !== 4'(exp_b(n - 1))) begin
        n_fail++;
        $display("FAIL silence_gain line %0d: got a=%0d b=%0d expected a=%0d b=%0d",
                 n, snap_gain_a, snap_gain_b, exp_a(n - 1), exp_b(n - 1));
      end
    end
  endtask

  task automatic test_reset_mid_ramp;
    run_line(1, 400, 1'b0, 1'b0);
    n_tests++;
    if (snap_gain_a !== 4'd9) begin
      n_fail++;
      $display("FAIL pre_reset_gain: got %0d expected 9", snap_gain_a);
    end
    check_reset_snap("reset_mid_ramp");
  endtask

  task automatic test_full_ramp;
    int want_lvl;
    for (int k = 1; k <= 18; k++) begin
      run_line(1, -1, 1'b0, 1'b0);
      n_tests++;
      if (snap_gain_a !== 4'(exp_a(k))) begin
        n_fail++;
        $display("FAIL ramp_gain_a strobe %0d: got %0d expected %0d", k, snap_gain_a, exp_a(k));
      end
      n_tests++;
      if (snap_gain_b !== 4'(exp_b(k))) begin
        n_fail++;
        $display("FAIL ramp_gain_b strobe %0d: got %0d expected %0d", k, snap_gain_b, exp_b(k));
      end
      want_lvl = (k == 1) ? 399 : 800;
      n_tests++;
      if (snap_lvl_a !== 10'(want_lvl)) begin
        n_fail++;
        $display("FAIL ramp_level strobe %0d: got %0d expected %0d", k, snap_lvl_a, want_lvl);
      end
      if (k >= 17) begin
        n_tests++;
        if (ones_a != 750) begin
          n_fail++;
          $display("FAIL full_scale_ones line %0d: got %0d expected 750", k, ones_a);
        end
      end
    end
  endtask

  task automatic test_density;
    run_line(2, -1, 1'b0, 1'b0);
    run_line(2, -1, 1'b0, 1'b0);
    n_tests++;
    if (snap_lvl_a !== 10'd256 || snap_gain_a !== 4'd15) begin
      n_fail++;
      $display("FAIL density_level: got level=%0d gain=%0d expected level=256 gain=15", snap_lvl_a, snap_gain_a);
    end
    run_line(2, -1, 1'b0, 1'b0);
    n_tests++;
    if (ones_a != 240) begin
      n_fail++;
      $display("FAIL density_ones: got %0d expected 240", ones_a);
    end
  endtask

  task automatic test_no_strobe;
    run_line(0, -1, 1'b0, 1'b1);
    x = 10'd0; sound = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (level_a !== 10'd256 || gain_a !== 4'd15) begin
      n_fail++;
      $display("FAIL no_strobe_hold: got level=%0d gain=%0d expected level=256 gain=15", level_a, gain_a);
    end
  endtask

  task automatic test_ramp_reversal;
    bit en_tab[38] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,
                       0,0,0,0,0,0,0,1,1,1,1,1,1,1,0,1,1,1};
    int g_tab[38]  = '{0,0,1,1,2,2,3,3,4,4,5,5,6,6,6,5,5,4,4,3,
                       3,2,2,1,1,0,0,0,0,1,1,2,2,3,3,3,3,4};
    enable = 1'b1;
    run_line(0, 0, 1'b0, 1'b0);
    check_reset_snap("reset_line_start");
    for (int l = 1; l <= 38; l++) begin
      enable = en_tab[l - 1];
      run_line(0, -1, (l == 20 || l == 27), 1'b0);
      n_tests++;
      if (snap_gain_b !== 4'(g_tab[l - 1])) begin
        n_fail++;
        $display("FAIL reversal_gain_b strobe %0d: got %0d expected %0d", l, snap_gain_b, g_tab[l - 1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef AUDIO_IIR_EN
    test_iir;
`else
    test_silence;
    test_reset_mid_ramp;
    test_full_ramp;
    test_density;
    test_no_strobe;
    test_ramp_reversal;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_pdm_out.md
# audio_pdm_out

Downstream audio output stage for the 1-bit `sound` signal produced by the sound generator. It measures the per-line duty of `sound` (the generator encodes its envelope as a pulse width within each scanline) and converts it to a line-rate amplitude sample, optionally smoothing it with an IIR filter. A mute/fade state machine applies the gain, and a first-order sigma-delta modulator drives the single pin that feeds the board's RC audio filter.

## Interface
- `H_TOTAL`, 800: pixel clocks per scanline; `x` counts 0..H_TOTAL-1.
- `FADE_DIV`, 4: line strobes per gain step during ramps (1..255).
- `IIR_SHIFT`, 3: IIR smoothing shift (1..8).
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `sound`  in  1  raw sound bit from the generator.
- `x`  in  10  current horizontal pixel position.
- `enable`  in  1  request audio on (level-sensitive).
- `audio_out`  out  1  registered PDM bitstream.
- `gain`  out  4  current gain, 0..15.
- `level`  out  10  current smoothed amplitude.

## Operation
- **Line accumulator:**
  - 10-bit `pix_count` adds `sound` every cycle.
  - On the cycle with `x == H_TOTAL-1`, `sample <= pix_count + sound` and `pix_count <= 0`.
  - `line_strobe` is a one-cycle registered pulse on the following cycle.
  - `sample` range is 0..H_TOTAL; 800 fits in 10 bits with no saturation needed.
- **Level:** on `line_strobe`, `level` updates per Configuration.
- **Gain FSM:** states MUTE, RAMP_UP, PLAY, RAMP_DOWN. All changes occur only on `line_strobe`. An 8-bit divider counts strobes and resets on every state change.
  - MUTE: `gain` is 0. If `enable`, go to RAMP_UP.
  - RAMP_UP: every FADE_DIV strobes, `gain` increments. When `gain` becomes 15, go to PLAY. If `!enable`, go to RAMP_DOWN without changing `gain`.
  - PLAY: `gain` is 15. If `!enable`, go to RAMP_DOWN.
  - RAMP_DOWN: every FADE_DIV strobes, `gain` decrements. When `gain` becomes 0, go to MUTE. If `enable`, go to RAMP_UP without changing `gain`.
  - `enable` is evaluated before the divider step. A state change on a strobe suppresses that strobe's gain step.
- **Scaling:** `scaled = (level * gain) >> 4`, truncated, 10 bits, maximum 750.
- **Sigma-delta:** 11-bit `acc`. Every cycle compute `sum = acc + scaled`.
  - If `sum >= H_TOTAL`: `audio_out <= 1`, `acc <= sum - H_TOTAL`.
  - Otherwise: `audio_out <= 0`, `acc <= sum`.
  - Ones density equals `scaled / H_TOTAL` exactly over any H_TOTAL-cycle window with constant `scaled`.

## Timing
- Reset values: `audio_out` 0, `gain` 0, `level` 0, `pix_count` 0, `sample` 0, `acc` 0, divider 0, state MUTE, `line_strobe` 0.
- Reset asserted mid-line or mid-ramp returns everything to the reset values on the next edge. After release, the first `sample` covers only the partial line and is used as-is.
- Latencies:
  - `sample` is valid 1 cycle after `x == H_TOTAL-1`.
  - `level` and `gain` update 1 cycle after `line_strobe`.
  - `audio_out` reflects the new `scaled` 1 cycle after that.
- `x` is not range-checked. If `x` never equals H_TOTAL-1, `pix_count` wraps mod 1024 and no strobe occurs. `level` and `gain` hold.
- `enable` toggling between strobes has no effect. Only the value sampled on the strobe cycle matters.

## Configuration
- `AUDIO_IIR_EN` defined:
  - On each strobe, `level <= level + ((sample - level) >>> IIR_SHIFT)`, computed as 11-bit signed with arithmetic (floor) shift.
  - Rising steps settle up to 2^IIR_SHIFT-1 below the target.
  - Falling steps reach the target exactly.
- `AUDIO_IIR_EN` undefined: `level <= sample` on each strobe, and the `IIR_SHIFT` parameter is ignored.

## Test plan
- **Full-scale ramp** (FADE_DIV=1, IIR off): `sound=1` held, `enable=1` from reset. Required response:
  - `gain` reads 1..15 on successive strobes; PLAY is reached after 15 strobes.
  - `level` is 800 and `scaled` is 750.
  - `audio_out` shows 750 ones in every 800-cycle window.
- **Density** (IIR off, PLAY): `sound` high for x in 256..511 (256 pixels per line). Required response: `level=256`, `scaled=240`, exactly 240 ones per 800 cycles.
- **Silence:** `sound=0`, `enable=1`. Required response: `audio_out` stays 0 for 10 lines and `level` stays 0.
- **Ramp reversal** (FADE_DIV=2): `enable` drops while RAMP_UP is at `gain=6`.
  - Required: the next strobe enters RAMP_DOWN with `gain` still 6.
  - Then one step per 2 strobes down to 0, then MUTE.
  - Reasserting `enable` at `gain=3` goes back to RAMP_UP with `gain=3`.
- **IIR step** (AUDIO_IIR_EN, IIR_SHIFT=3): `sample` steps 0→800. Required:
  - `level` reads 100, 187, 263 on the next strobes and settles at 793.
  - After `sample` drops to 0, `level` reaches exactly 0.
- **Reset mid-ramp:** assert `rst_n=0` for 1 cycle at `x=400` during RAMP_UP with `gain=9`. Required: the next cycle shows all outputs at reset values and state MUTE. Ramp restarts from `gain=0`.
